axi_rr_arbiter: RTL and testbench

AXI_RR_ARBITER -- requirements
Module: axi_rr_arbiter

---
 rtl/axi_rr_arbiter_pkg.sv | 22 ++
 rtl/rr_picker.sv | 34 +++
 rtl/axi_rr_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_rr_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rr_arbiter_pkg.sv
// Shared AXI constants, FSM state encoding and helpers for the round-robin
// cache-to-AXI arbiter.
package axi_rr_arbiter_pkg;

   localparam logic [1:0] BURST_INCR    = 2'b01;
   localparam logic [1:0] RESP_OKAY     = 2'b00;
   localparam logic [3:0] CACHE_DEFAULT = 4'b0010;

   typedef enum logic [2:0] {
      StIdle,
      StAr,
      StR,
      StAwW,
      StB
   } state_e;

   // AXI size code for a full-width beat.
   function automatic logic [2:0] axi_size(input int unsigned data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the search starts one past the last
// grant and wraps, returning a one-hot grant and its index.
module rr_picker #(
   parameter int unsigned NUM_MST = 2,
   parameter int unsigned IDX_W   = 1
) (
   input  logic [NUM_MST-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_MST-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               valid
);

   int unsigned j;
   logic        found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int unsigned i = 1; i <= NUM_MST; i++) begin
         j = (32'(last) + i) % NUM_MST;
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDX_W'(j);
         end
      end
   end

   assign valid = found;

endmodule

// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter letting NUM_MST cache masters share one AXI4 port,
// one transaction at a time: burst reads or single-beat writes.
module axi_rr_arbiter
   import axi_rr_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MST = 2,
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned ID_W    = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_MST-1:0]          m_req,
   input  logic [NUM_MST-1:0]          m_we,
   input  logic [NUM_MST*ADDR_W-1:0]   m_addr,
   input  logic [NUM_MST*DATA_W-1:0]   m_wdata,
   input  logic [NUM_MST*DATA_W/8-1:0] m_wmask,
   input  logic [NUM_MST*8-1:0]        m_len,
   output logic [DATA_W-1:0]           m_rdata,
   output logic [NUM_MST-1:0]          m_rvalid,
   output logic [NUM_MST-1:0]          m_done,
   output logic [NUM_MST-1:0]          m_err,
   output logic                        axi_aw_valid,
   input  logic                        axi_aw_ready,
   output logic [ID_W-1:0]             axi_aw_id,
   output logic [ADDR_W-1:0]           axi_aw_addr,
   output logic [7:0]                  axi_aw_len,
   output logic [2:0]                  axi_aw_size,
   output logic [1:0]                  axi_aw_burst,
   output logic                        axi_aw_lock,
   output logic [3:0]                  axi_aw_cache,
   output logic [2:0]                  axi_aw_prot,
   output logic [3:0]                  axi_aw_qos,
   output logic                        axi_w_valid,
   input  logic                        axi_w_ready,
   output logic [DATA_W-1:0]           axi_w_data,
   output logic [DATA_W/8-1:0]         axi_w_strb,
   output logic                        axi_w_last,
   input  logic                        axi_b_valid,
   output logic                        axi_b_ready,
   input  logic [ID_W-1:0]             axi_b_id,
   input  logic [1:0]                  axi_b_resp,
   output logic                        axi_ar_valid,
   input  logic                        axi_ar_ready,
   output logic [ID_W-1:0]             axi_ar_id,
   output logic [ADDR_W-1:0]           axi_ar_addr,
   output logic [7:0]                  axi_ar_len,
   output logic [2:0]                  axi_ar_size,
   output logic [1:0]                  axi_ar_burst,
   output logic                        axi_ar_lock,
   output logic [3:0]                  axi_ar_cache,
   output logic [2:0]                  axi_ar_prot,
   output logic [3:0]                  axi_ar_qos,
   input  logic                        axi_r_valid,
   output logic                        axi_r_ready,
   input  logic [ID_W-1:0]             axi_r_id,
   input  logic [DATA_W-1:0]           axi_r_data,
   input  logic [1:0]                  axi_r_resp,
   input  logic                        axi_r_last
);

   localparam int unsigned IDX_W  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
   localparam int unsigned STRB_W = DATA_W / 8;

   state_e               state_q;
   logic [IDX_W-1:0]     grant_q, last_q, pick_idx;
   logic [NUM_MST-1:0]   gnt_oh_q, pick_gnt;
   logic                 pick_valid;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [STRB_W-1:0]    wmask_q;
   logic [7:0]           len_q, beat_q;
   logic [2:0]           size_q;
   logic [1:0]           burst_q;
   logic [3:0]           cache_q;
   logic                 err_q;
   logic                 ar_valid_q, r_ready_q, aw_valid_q, w_valid_q, b_ready_q;
   logic                 r_beat, r_final, r_err, r_fin, b_fin, aw_done, w_done;
   logic                 unused_ids;

   rr_picker #(
      .NUM_MST (NUM_MST),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req   (m_req),
      .last  (last_q),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // A burst ends on r_last or on its len+1-th beat; any disagreement between
   // the two is a protocol error reported to the master.
   assign r_beat  = (state_q == StR) && axi_r_valid;
   assign r_final = axi_r_last || (beat_q == len_q);
   assign r_err   = err_q || (axi_r_resp != RESP_OKAY) || (axi_r_last != (beat_q == len_q));
   assign r_fin   = r_beat && r_final;
   assign b_fin   = (state_q == StB) && axi_b_valid;
   assign aw_done = !aw_valid_q || axi_aw_ready;
   assign w_done  = !w_valid_q || axi_w_ready;

   assign m_rdata  = axi_r_data;
   assign m_rvalid = gnt_oh_q & {NUM_MST{r_beat}};
   assign m_done   = gnt_oh_q & {NUM_MST{r_fin || b_fin}};
   assign m_err    = gnt_oh_q & {NUM_MST{(r_fin && r_err) ||
                                         (b_fin && (axi_b_resp != RESP_OKAY))}};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         grant_q    <= '0;
         gnt_oh_q   <= '0;
         last_q     <= IDX_W'(NUM_MST - 1);
         addr_q     <= '0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         len_q      <= '0;
         beat_q     <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         cache_q    <= '0;
         err_q      <= 1'b0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         b_ready_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pick_valid) begin
                  grant_q  <= pick_idx;
                  gnt_oh_q <= pick_gnt;
                  last_q   <= pick_idx;
                  addr_q   <= m_addr[pick_idx*ADDR_W +: ADDR_W];
                  wdata_q  <= m_wdata[pick_idx*DATA_W +: DATA_W];
                  wmask_q  <= m_wmask[pick_idx*STRB_W +: STRB_W];
                  len_q    <= m_len[pick_idx*8 +: 8];
                  size_q   <= axi_size(DATA_W);
                  burst_q  <= BURST_INCR;
                  cache_q  <= CACHE_DEFAULT;
                  beat_q   <= '0;
                  err_q    <= 1'b0;
                  if (m_we[pick_idx]) begin
                     aw_valid_q <= 1'b1;
                     w_valid_q  <= 1'b1;
                     state_q    <= StAwW;
                  end else begin
                     ar_valid_q <= 1'b1;
                     state_q    <= StAr;
                  end
               end
            end
            StAr: begin
               if (axi_ar_ready) begin
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
                  state_q    <= StR;
               end
            end
            StR: begin
               if (axi_r_valid) begin
                  if (r_final) begin
                     r_ready_q <= 1'b0;
                     beat_q    <= '0;
                     state_q   <= StIdle;
                  end else begin
                     beat_q <= beat_q + 8'd1;
                     err_q  <= r_err;
                  end
               end
            end
            StAwW: begin
               if (axi_aw_ready) aw_valid_q <= 1'b0;
               if (axi_w_ready) w_valid_q <= 1'b0;
               if (aw_done && w_done) begin
                  b_ready_q <= 1'b1;
                  state_q   <= StB;
               end
            end
            StB: begin
               if (axi_b_valid) begin
                  b_ready_q <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign axi_ar_valid = ar_valid_q;
   assign axi_ar_id    = ID_W'(grant_q);
   assign axi_ar_addr  = addr_q;
   assign axi_ar_len   = len_q;
   assign axi_ar_size  = size_q;
   assign axi_ar_burst = burst_q;
   assign axi_ar_lock  = 1'b0;
   assign axi_ar_cache = cache_q;
   assign axi_ar_prot  = 3'b000;
   assign axi_ar_qos   = 4'b0000;
   assign axi_r_ready  = r_ready_q;

   assign axi_aw_valid = aw_valid_q;
   assign axi_aw_id    = ID_W'(grant_q);
   assign axi_aw_addr  = addr_q;
   assign axi_aw_len   = 8'd0;
   assign axi_aw_size  = size_q;
   assign axi_aw_burst = burst_q;
   assign axi_aw_lock  = 1'b0;
   assign axi_aw_cache = cache_q;
   assign axi_aw_prot  = 3'b000;
   assign axi_aw_qos   = 4'b0000;
   assign axi_w_valid  = w_valid_q;
   assign axi_w_data   = wdata_q;
   assign axi_w_strb   = wmask_q;
   assign axi_w_last   = w_valid_q;
   assign axi_b_ready  = b_ready_q;

   // Only one transaction is ever outstanding, so response ids carry no info.
   assign unused_ids = ^{axi_r_id, axi_b_id};

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter: a 2-master instance driven by hand and a
// 4-master instance against an always-ready slave for grant-order checks.
module tb_axi_rr_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rst4 = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // 2-master instance
   logic [1:0]   m_req = '0, m_we = '0;
   logic [127:0] m_addr = '0, m_wdata = '0;
   logic [15:0]  m_wmask = '0, m_len = '0;
   logic [63:0]  m_rdata;
   logic [1:0]   m_rvalid, m_done, m_err;
   logic         aw_valid, aw_ready = 1'b0, aw_lock, w_valid, w_ready = 1'b0, w_last;
   logic [3:0]   aw_id, aw_cache, aw_qos, ar_id, ar_cache, ar_qos;
   logic [63:0]  aw_addr, ar_addr, w_data;
   logic [7:0]   aw_len, ar_len, w_strb;
   logic [2:0]   aw_size, aw_prot, ar_size, ar_prot;
   logic [1:0]   aw_burst, ar_burst;
   logic         b_valid = 1'b0, b_ready;
   logic [1:0]   b_resp = 2'b00, r_resp = 2'b00;
   logic         ar_valid, ar_ready = 1'b0, ar_lock;
   logic         r_valid = 1'b0, r_ready, r_last = 1'b0;
   logic [63:0]  r_data = '0;

   axi_rr_arbiter #(.NUM_MST(2)) dut (
      .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_wmask(m_wmask), .m_len(m_len), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
      .m_done(m_done), .m_err(m_err),
      .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready), .axi_aw_id(aw_id),
      .axi_aw_addr(aw_addr), .axi_aw_len(aw_len), .axi_aw_size(aw_size),
      .axi_aw_burst(aw_burst), .axi_aw_lock(aw_lock), .axi_aw_cache(aw_cache),
      .axi_aw_prot(aw_prot), .axi_aw_qos(aw_qos),
      .axi_w_valid(w_valid), .axi_w_ready(w_ready), .axi_w_data(w_data),
      .axi_w_strb(w_strb), .axi_w_last(w_last),
      .axi_b_valid(b_valid), .axi_b_ready(b_ready), .axi_b_id(4'd0), .axi_b_resp(b_resp),
      .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready), .axi_ar_id(ar_id),
      .axi_ar_addr(ar_addr), .axi_ar_len(ar_len), .axi_ar_size(ar_size),
      .axi_ar_burst(ar_burst), .axi_ar_lock(ar_lock), .axi_ar_cache(ar_cache),
      .axi_ar_prot(ar_prot), .axi_ar_qos(ar_qos),
      .axi_r_valid(r_valid), .axi_r_ready(r_ready), .axi_r_id(4'd0), .axi_r_data(r_data),
      .axi_r_resp(r_resp), .axi_r_last(r_last)
   );

   // 4-master instance, all requests held, slave always ready with 1-beat reads
   logic [63:0]  m4_rdata;
   logic [3:0]   m4_rvalid, m4_done, m4_err;
   logic         aw4_valid, aw4_lock, w4_valid, w4_last, b4_ready, ar4_valid, ar4_lock, r4_ready;
   logic [3:0]   aw4_id, aw4_cache, aw4_qos, ar4_id, ar4_cache, ar4_qos;
   logic [63:0]  aw4_addr, ar4_addr, w4_data;
   logic [7:0]   aw4_len, ar4_len, w4_strb;
   logic [2:0]   aw4_size, aw4_prot, ar4_size, ar4_prot;
   logic [1:0]   aw4_burst, ar4_burst;

   axi_rr_arbiter #(.NUM_MST(4)) dut4 (
      .clk(clk), .rst(rst4), .m_req(4'hF), .m_we(4'h0), .m_addr(256'd0), .m_wdata(256'd0),
      .m_wmask(32'd0), .m_len(32'd0), .m_rdata(m4_rdata), .m_rvalid(m4_rvalid),
      .m_done(m4_done), .m_err(m4_err),
      .axi_aw_valid(aw4_valid), .axi_aw_ready(1'b1), .axi_aw_id(aw4_id),
      .axi_aw_addr(aw4_addr), .axi_aw_len(aw4_len), .axi_aw_size(aw4_size),
      .axi_aw_burst(aw4_burst), .axi_aw_lock(aw4_lock), .axi_aw_cache(aw4_cache),
      .axi_aw_prot(aw4_prot), .axi_aw_qos(aw4_qos),
      .axi_w_valid(w4_valid), .axi_w_ready(1'b1), .axi_w_data(w4_data),
      .axi_w_strb(w4_strb), .axi_w_last(w4_last),
      .axi_b_valid(1'b1), .axi_b_ready(b4_ready), .axi_b_id(4'd0), .axi_b_resp(2'b00),
      .axi_ar_valid(ar4_valid), .axi_ar_ready(1'b1), .axi_ar_id(ar4_id),
      .axi_ar_addr(ar4_addr), .axi_ar_len(ar4_len), .axi_ar_size(ar4_size),
      .axi_ar_burst(ar4_burst), .axi_ar_lock(ar4_lock), .axi_ar_cache(ar4_cache),
      .axi_ar_prot(ar4_prot), .axi_ar_qos(ar4_qos),
      .axi_r_valid(1'b1), .axi_r_ready(r4_ready), .axi_r_id(4'd0), .axi_r_data(64'd0),
      .axi_r_resp(2'b00), .axi_r_last(1'b1)
   );

   int         n4 = 0;
   logic [3:0] order4 [8];

   always @(posedge clk) begin
      if (rst4 && ar4_valid) begin
         if (n4 < 8) order4[n4] <= ar4_id;
         n4 <= n4 + 1;
      end
   end

   initial begin
      // Reset
      repeat (3) tick();
      check("rst_ar_valid", 64'(ar_valid), 64'd0);
      check("rst_aw_w_valid", 64'({aw_valid, w_valid}), 64'd0);
      check("rst_readies", 64'({r_ready, b_ready}), 64'd0);
      check("rst_m_outs", 64'({m_rvalid, m_done, m_err}), 64'd0);
      check("rst_payload", 64'({ar_addr[15:0], ar_burst, ar_cache, aw_size}), 64'd0);

      // Two simultaneous reads: master 0 first
      rst    = 1'b1;
      m_req  = 2'b11;
      m_addr = {64'h8000_1000, 64'h8000_0000};
      m_len  = {8'd3, 8'd0};
      tick();
      check("rd0_ar_valid", 64'(ar_valid), 64'd1);
      check("rd0_ar_id", 64'(ar_id), 64'd0);
      check("rd0_ar_addr", ar_addr, 64'h8000_0000);
      check("rd0_ar_attr", 64'({ar_len, ar_size, ar_burst, ar_cache}),
            64'({8'd0, 3'd3, 2'b01, 4'b0010}));
      ar_ready = 1'b1;
      tick();
      ar_ready = 1'b0;
      check("rd0_ar_drop", 64'({ar_valid, r_ready}), 64'b01);
      r_valid = 1'b1; r_data = 64'h55; r_last = 1'b1;
      #1;
      check("rd0_beat", 64'({m_rvalid, m_done, m_err}), 64'b01_01_00);
      check("rd0_rdata", m_rdata, 64'h55);
      m_req = 2'b10;
      tick();
      r_valid = 1'b0; r_last = 1'b0;
      check("turnaround_idle", 64'({ar_valid, m_done}), 64'd0);
      tick();
      check("rd1_ar_id", 64'(ar_id), 64'd1);
      check("rd1_ar_addr", ar_addr, 64'h8000_1000);
      check("rd1_ar_len", 64'(ar_len), 64'd3);

      // Master 1 four-beat read with 2-cycle gaps
      ar_ready = 1'b1;
      tick();
      ar_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         repeat (2) begin
            tick();
            check("rd1_gap", 64'(m_rvalid), 64'd0);
         end
         r_valid = 1'b1; r_data = 64'hA0 + 64'(k); r_last = (k == 3);
         #1;
         check("rd1_rvalid", 64'(m_rvalid), 64'b10);
         check("rd1_rdata", m_rdata, 64'hA0 + 64'(k));
         check("rd1_done", 64'({m_done, m_err}), (k == 3) ? 64'b10_00 : 64'd0);
         if (k == 3) m_req = 2'b00;
         tick();
         r_valid = 1'b0; r_last = 1'b0;
      end

      // Master 0 write, W accepted two cycles before AW
      m_req   = 2'b01;
      m_we    = 2'b01;
      m_wdata = {64'd0, 64'h1122_3344_5566_7788};
      m_wmask = {8'h00, 8'h0F};
      tick();
      check("wr_valids", 64'({aw_valid, w_valid, w_last}), 64'b111);
      check("wr_data", w_data, 64'h1122_3344_5566_7788);
      check("wr_strb_len_id", 64'({w_strb, aw_len, aw_id}), 64'({8'h0F, 8'd0, 4'd0}));
      w_ready = 1'b1;
      tick();
      w_ready = 1'b0;
      check("wr_w_only", 64'({aw_valid, w_valid, b_ready}), 64'b100);
      tick();
      check("wr_wait_aw", 64'({aw_valid, w_valid, b_ready}), 64'b100);
      aw_ready = 1'b1;
      tick();
      aw_ready = 1'b0;
      check("wr_in_b", 64'({aw_valid, b_ready}), 64'b01);
      b_valid = 1'b1;
      #1;
      check("wr_done", 64'({m_done, m_err}), 64'b01_00);
      m_req = 2'b00;
      tick();
      b_valid = 1'b0;

      // Master 1 write with SLVERR, AW and W in the same cycle
      m_req = 2'b10;
      m_we  = 2'b10;
      tick();
      aw_ready = 1'b1; w_ready = 1'b1;
      tick();
      aw_ready = 1'b0; w_ready = 1'b0;
      check("slverr_b_ready", 64'(b_ready), 64'd1);
      b_valid = 1'b1; b_resp = 2'b10;
      #1;
      check("slverr_done", 64'({m_done, m_err}), 64'b10_10);
      m_req = 2'b00;
      tick();
      b_valid = 1'b0; b_resp = 2'b00;

      // Master 0 read len=1, r_last one beat early
      m_req = 2'b01;
      m_we  = 2'b00;
      m_len = {8'd3, 8'd1};
      tick();
      ar_ready = 1'b1;
      tick();
      ar_ready = 1'b0;
      r_valid = 1'b1; r_last = 1'b1; r_data = 64'h1;
      #1;
      check("early_last", 64'({m_done, m_err}), 64'b01_01);
      m_req = 2'b00;
      tick();
      r_valid = 1'b0; r_last = 1'b0;

      // Same read, r_last missing on the final beat
      m_req = 2'b01;
      tick();
      ar_ready = 1'b1;
      tick();
      ar_ready = 1'b0;
      r_valid = 1'b1;
      #1;
      check("late_beat0", 64'({m_rvalid, m_done, m_err}), 64'b01_00_00);
      tick();
      check("late_beat1", 64'({m_rvalid, m_done, m_err}), 64'b01_01_01);
      m_req = 2'b00;
      tick();
      r_valid = 1'b0;
      check("late_idle_r_ready", 64'(r_ready), 64'd0);

      // Reset during a 4-beat read after beat 1
      m_req = 2'b10;
      tick();
      ar_ready = 1'b1;
      tick();
      ar_ready = 1'b0;
      r_valid = 1'b1; r_data = 64'hA0;
      #1;
      check("rst_mid_beat0", 64'(m_rvalid), 64'b10);
      tick();
      r_valid = 1'b0;
      rst = 1'b0;
      tick();
      check("rst_mid_outs", 64'({r_ready, ar_valid, m_rvalid, m_done, m_err}), 64'd0);
      rst = 1'b1;
      tick();
      check("post_rst_ar", 64'({ar_valid, ar_id}), 64'({1'b1, 4'd1}));
      ar_ready = 1'b1;
      tick();
      ar_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         r_valid = 1'b1; r_last = (k == 3); r_data = 64'hB0 + 64'(k);
         #1;
         check("post_rst_beat", 64'({m_rvalid, m_done, m_err}),
               (k == 3) ? 64'b10_10_00 : 64'b10_00_00);
         if (k == 3) m_req = 2'b00;
         tick();
      end
      r_valid = 1'b0; r_last = 1'b0;

      // Four-master fairness
      rst4 = 1'b1;
      for (int c = 0; c < 200 && n4 < 8; c++) tick();
      check("rr4_count", 64'(n4 >= 8), 64'd1);
      for (int k = 0; k < 8; k++) check("rr4_order", 64'(order4[k]), 64'(k % 4));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
